// File: rtl/csa_resolver_pkg.sv
// Shared definitions for the carry_save_adder datapath: operand sizing helpers
// and the resolver state encoding.
package csa_pkg;

   // Redundant operand width: data width plus CSA growth bits.
   function automatic int csa_d(input int w, input int e);
      return w + e;
   endfunction

   // Number of CH-bit slices needed to cover d bits (ceil division).
   function automatic int csa_nc(input int d, input int ch);
      return (d + ch - 1) / ch;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } csa_state_e;

endpackage

// File: rtl/csa_resolver_chunk_add.sv
// Combinational CH-bit slice adder used by the chunk-serial resolver.
module csa_chunk_add #(
   parameter int CH = 2
) (
   input  logic [CH-1:0] i_a,
   input  logic [CH-1:0] i_b,
   input  logic          i_ci,
   output logic [CH-1:0] o_s,
   output logic          o_co
);

   assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CH{1'b0}}, i_ci};

endmodule

// File: rtl/csa_resolver.sv
// Resolves one redundant (sum, cout) pair to a binary total, one CH-bit slice
// per clock, with valid/ready handshakes on both sides.
module csa_resolver
   import csa_pkg::*;
#(
   parameter  int W  = 3,
   parameter  int E  = 4,
   parameter  int CH = 2,
   localparam int D  = csa_d(W, E)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [D-1:0] sum,
   input  logic [D-1:0] cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [D:0]   res,
   output logic         busy
);

   localparam int NC = csa_nc(D, CH);
   localparam int PW = NC * CH;
   localparam int IW = (NC > 1) ? $clog2(NC) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

   csa_state_e    r_state;
   csa_state_e    w_state_nxt;
   logic [PW-1:0] r_a;
   logic [PW-1:0] r_b;
   logic [PW:0]   r_acc;
   logic [PW:0]   w_acc_nxt;
   logic [D:0]    r_res;
   logic          r_carry;
   logic          r_out_valid;
   logic [IW-1:0] r_idx;
   logic [CH-1:0] w_sa;
   logic [CH-1:0] w_sb;
   logic [CH-1:0] w_ss;
   logic          w_co;
   logic          w_last;

   assign w_sa   = r_a[int'(r_idx)*CH +: CH];
   assign w_sb   = r_b[int'(r_idx)*CH +: CH];
   assign w_last = (r_idx == LAST_IDX);

   csa_chunk_add #(.CH(CH)) u_chunk (
      .i_a  (w_sa),
      .i_b  (w_sb),
      .i_ci (r_carry),
      .o_s  (w_ss),
      .o_co (w_co)
   );

   // Top bit carries the final carry-out; only matters when D is a multiple of CH.
   always_comb begin
      w_acc_nxt                      = r_acc;
      w_acc_nxt[int'(r_idx)*CH +: CH] = w_ss;
      w_acc_nxt[PW]                  = w_co;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (in_valid)  w_state_nxt = ST_ADD;
         ST_ADD:  if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_res       <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= PW'(sum);
                  r_b     <= PW'(cout);
                  r_acc   <= '0;
                  r_carry <= 1'b0;
                  r_idx   <= '0;
               end
            end
            ST_ADD: begin
               r_acc   <= w_acc_nxt;
               r_carry <= w_co;
               r_idx   <= r_idx + IW'(1);
               // res is only updated once the whole total is known, so a reset
               // mid-operation never exposes a partial result.
               if (w_last) begin
                  r_res       <= w_acc_nxt[D:0];
                  r_out_valid <= 1'b1;
                  r_idx       <= '0;
               end
            end
            ST_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_out_valid;
   assign res       = r_res;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed scenarios on CH=2 plus a
// randomized end-to-end run on CH=2 and CH=3 against plain-arithmetic totals.
module tb_csa_resolver;

   localparam int W   = 3;
   localparam int E   = 4;
   localparam int D   = 7;
   localparam int NCA = 4;
   localparam int NCB = 3;
   localparam int NPAIRS = 2500;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic         b_out_ready;
   logic [D-1:0] sum;
   logic [D-1:0] cout;
   logic         a_in_ready, a_out_valid, a_busy;
   logic [D:0]   a_res;
   logic         b_in_ready, b_out_valid, b_busy;
   logic [D:0]   b_res;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   csa_resolver #(.W(W), .E(E), .CH(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .sum(sum), .cout(cout), .out_valid(a_out_valid), .out_ready(out_ready),
      .res(a_res), .busy(a_busy)
   );

   csa_resolver #(.W(W), .E(E), .CH(3)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .sum(sum), .cout(cout), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .res(b_res), .busy(b_busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic accept_a(input logic [D-1:0] s, input logic [D-1:0] k);
      int g;
      g = 0;
      while (!a_in_ready && g < 40) begin tick(); g++; end
      n_cmp++;
      if (!a_in_ready) begin
         n_err++;
         $display("FAIL accept_wait: in_ready=%0b after %0d cycles, required 1", a_in_ready, g);
      end
      sum = s; cout = k; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid_a(output int lat);
      lat = 0;
      while (!a_out_valid && lat < 40) begin tick(); lat++; end
   endtask

   task automatic run_pair_a(input logic [D-1:0] s, input logic [D-1:0] k, input string nm);
      logic [D:0] exp_v;
      int lat;
      exp_v = (D+1)'(int'(s) + int'(k));
      accept_a(s, k);
      wait_valid_a(lat);
      n_cmp++;
      if (lat != NCA) begin
         n_err++; $display("FAIL %s_latency: got %0d edges, required %0d", nm, lat, NCA);
      end
      n_cmp++;
      if (a_res !== exp_v) begin
         n_err++; $display("FAIL %s_res: got %h, required %h", nm, a_res, exp_v);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_res !== exp_v) begin
         n_err++;
         $display("FAIL %s_handshake: out_valid=%b in_ready=%b res=%h, required 0 1 %h",
                  nm, a_out_valid, a_in_ready, a_res, exp_v);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; b_out_ready = 1'b1;
      sum = '0; cout = '0;
      tick(); tick();
      rst = 1'b0;
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_res !== '0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset: out_valid=%b res=%h busy=%b in_ready=%b, required 0 00 0 1",
                  a_out_valid, a_res, a_busy, a_in_ready);
      end
   endtask

   task automatic test_max;
      run_pair_a(7'h7F, 7'h7F, "max");
   endtask

   task automatic test_patterns;
      run_pair_a(7'h55, 7'h2B, "p55_2b");
      run_pair_a(7'h00, 7'h00, "zero");
      run_pair_a(7'h40, 7'h40, "carry_top");
      run_pair_a(7'h01, 7'h7F, "ripple");
   endtask

   task automatic test_back_to_back;
      int c1, lat;
      out_ready = 1'b1;
      accept_a(7'h33, 7'h0D);
      c1 = cyc;
      wait_valid_a(lat);
      n_cmp++;
      if (a_res !== 8'h40) begin
         n_err++; $display("FAIL b2b_res1: got %h, required 40", a_res);
      end
      tick();
      accept_a(7'h11, 7'h22);
      n_cmp++;
      if (cyc - c1 != NCA + 2) begin
         n_err++; $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - c1, NCA + 2);
      end
      wait_valid_a(lat);
      n_cmp++;
      if (a_res !== 8'h33) begin
         n_err++; $display("FAIL b2b_res2: got %h, required 33", a_res);
      end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      int lat;
      accept_a(7'h12, 7'h34);
      wait_valid_a(lat);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin in_valid = 1'b1; sum = 7'h7F; cout = 7'h01; end
         tick();
         in_valid = 1'b0;
         n_cmp++;
         if (a_out_valid !== 1'b1 || a_res !== 8'h46 || a_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_%0d: out_valid=%b res=%h in_ready=%b, required 1 46 0",
                     i, a_out_valid, a_res, a_in_ready);
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stall_release: in_ready=%b out_valid=%b, required 1 0", a_in_ready, a_out_valid);
      end
      tick();
      n_cmp++;
      if (a_busy !== 1'b0) begin
         n_err++; $display("FAIL stall_pulse_ignored: busy=%b, required 0", a_busy);
      end
   endtask

   task automatic test_reset_mid_add;
      logic seen;
      accept_a(7'h3C, 7'h0F);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_idle: busy=%b out_valid=%b in_ready=%b, required 0 0 1",
                  a_busy, a_out_valid, a_in_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < NCA + 2; i++) begin
         tick();
         if (a_out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++; $display("FAIL midreset_no_output: out_valid rose=%b, required 0", seen);
      end
      run_pair_a(7'h21, 7'h5E, "after_reset");
   endtask

   task automatic test_random;
      logic [D-1:0] s, k;
      logic [D:0]   exp_v;
      int tot, acc_c, g;
      logic done_a, done_b, seen_a, seen_b;
      b_out_ready = 1'b0;
      for (int p = 0; p < NPAIRS; p++) begin
         // Half the pairs model a 17-input CSA tree of W-bit slices; half are arbitrary.
         if ($urandom_range(0, 1) == 1) begin
            tot = 0;
            for (int j = 0; j < 17; j++) tot += int'($urandom_range(0, 7));
            s = D'($urandom_range(0, tot));
            k = D'(tot - int'(s));
         end else begin
            s = D'($urandom);
            k = D'($urandom);
         end
         exp_v = (D+1)'(int'(s) + int'(k));
         g = 0;
         while (!(a_in_ready && b_in_ready) && g < 40) begin tick(); g++; end
         n_cmp++;
         if (!(a_in_ready && b_in_ready)) begin
            n_err++; $display("FAIL rnd_ready_%0d: a=%b b=%b, required 1 1", p, a_in_ready, b_in_ready);
         end
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
         sum = s; cout = k; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         acc_c = cyc;
         sum = D'($urandom); cout = D'($urandom);
         done_a = 0; done_b = 0; seen_a = 0; seen_b = 0;
         for (int it = 0; it < 60 && !(done_a && done_b); it++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            if (a_out_valid && !done_a) begin
               if (!seen_a) begin
                  seen_a = 1;
                  n_cmp++;
                  if (cyc - acc_c != NCA) begin
                     n_err++; $display("FAIL rnd_lat_a_%0d: got %0d, required %0d", p, cyc - acc_c, NCA);
                  end
               end
               if (out_ready) begin
                  done_a = 1;
                  n_cmp++;
                  if (a_res !== exp_v) begin
                     n_err++; $display("FAIL rnd_res_a_%0d: %h+%h got %h, required %h", p, s, k, a_res, exp_v);
                  end
               end
            end
            if (b_out_valid && !done_b) begin
               if (!seen_b) begin
                  seen_b = 1;
                  n_cmp++;
                  if (cyc - acc_c != NCB) begin
                     n_err++; $display("FAIL rnd_lat_b_%0d: got %0d, required %0d", p, cyc - acc_c, NCB);
                  end
               end
               if (b_out_ready) begin
                  done_b = 1;
                  n_cmp++;
                  if (b_res !== exp_v) begin
                     n_err++; $display("FAIL rnd_res_b_%0d: %h+%h got %h, required %h", p, s, k, b_res, exp_v);
                  end
               end
            end
            tick();
         end
         out_ready = 1'b0; b_out_ready = 1'b0;
         if (!(done_a && done_b)) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_timeout_%0d: done_a=%b done_b=%b, required 1 1", p, done_a, done_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_max();
      test_patterns();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_add();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
